// File: rtl/maze_arb_pkg.sv
// maze_arb_pkg: shared state encodings and maze constants for the maze port arbiter
package maze_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam int COORD_W = 6;

   localparam logic CORRIDOR = 1'b0;
   localparam logic WALL     = 1'b1;

endpackage

// File: rtl/maze_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, searching upward from last+1 with wrap
module rr_picker #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   assign any = |req;

   // scan from farthest to nearest so the agent right after last overrides the others
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[IDX_W'((int'(last) + k) % NUM_REQ)]) winner = IDX_W'((int'(last) + k) % NUM_REQ);
      end
   end

endmodule

// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter: round-robin sharing of the single maze memory port with bounds checking
module maze_port_arbiter
   import maze_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 2,
   parameter  int MAZE_DIM = 64,
   localparam int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [COORD_W*NUM_REQ-1:0] req_row,
   input  logic [COORD_W*NUM_REQ-1:0] req_col,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         req_err,
   output logic [NUM_REQ-1:0]         rd_valid,
   output logic                       rd_data,
   output logic [COORD_W-1:0]         row,
   output logic [COORD_W-1:0]         col,
   output logic                       maze_oe,
   output logic                       maze_we,
   input  logic                       maze_in
);

   state_t             state, state_nx;
   logic [IDX_W-1:0]   last, cur, win;
   logic [NUM_REQ-1:0] win_oh, cur_oh;
   logic [COORD_W-1:0] w_row, w_col;
   logic               any, oob, is_rd;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req_valid),
      .last   (last),
      .winner (win),
      .any    (any)
   );

   assign w_row  = req_row[COORD_W*win +: COORD_W];
   assign w_col  = req_col[COORD_W*win +: COORD_W];
   assign win_oh = NUM_REQ'(1) << win;
   assign cur_oh = NUM_REQ'(1) << cur;
   assign oob    = ((COORD_W+1)'(w_row) >= (COORD_W+1)'(MAZE_DIM)) ||
                   ((COORD_W+1)'(w_col) >= (COORD_W+1)'(MAZE_DIM));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // next-state: a rejected or write request skips the read wait
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    state_nx = any ? ST_ISSUE : ST_IDLE;
         ST_ISSUE:   state_nx = is_rd ? ST_WAIT_RD : ST_IDLE;
         ST_WAIT_RD: state_nx = ST_CAPTURE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // registered grant, memory strobes, address and read return
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= '0;
         req_err  <= '0;
         rd_valid <= '0;
         rd_data  <= 1'b0;
         row      <= '0;
         col      <= '0;
         maze_oe  <= 1'b0;
         maze_we  <= 1'b0;
         last     <= IDX_W'(NUM_REQ-1);
         cur      <= '0;
         is_rd    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (any) begin
               gnt     <= win_oh;
               req_err <= oob ? win_oh : '0;
               last    <= win;
               cur     <= win;
               row     <= w_row;
               col     <= w_col;
               maze_we <= ~oob & req_we[win];
               maze_oe <= ~oob & ~req_we[win];
               is_rd   <= ~oob & ~req_we[win];
            end
            ST_ISSUE: begin
               gnt     <= '0;
               req_err <= '0;
               maze_oe <= 1'b0;
               maze_we <= 1'b0;
            end
            ST_WAIT_RD: begin
               rd_data  <= maze_in;
               rd_valid <= cur_oh;
            end
            default: rd_valid <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_port_arbiter.sv
// tb_maze_port_arbiter: directed checks of grant order, memory timing, bounds and reset
module tb_maze_port_arbiter;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_we = '0;
   logic [6*N-1:0] req_row = '0;
   logic [6*N-1:0] req_col = '0;
   logic [N-1:0] gnt, req_err, rd_valid;
   logic         rd_data, maze_oe, maze_we;
   logic [5:0]   row, col;
   logic         maze_in = 1'b0;
   logic [4095:0] marked = '0;
   int           checks = 0;
   int           errors = 0;

   maze_port_arbiter #(.NUM_REQ(N), .MAZE_DIM(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_row   (req_row),
      .req_col   (req_col),
      .gnt       (gnt),
      .req_err   (req_err),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .row       (row),
      .col       (col),
      .maze_oe   (maze_oe),
      .maze_we   (maze_we),
      .maze_in   (maze_in)
   );

   always #5 clk = ~clk;

   // maze memory: walls on odd row^col parity, plus any cell that was write-marked
   always @(posedge clk) begin
      if (maze_oe) maze_in <= marked[{row, col}] | (row[0] ^ col[0]);
      if (maze_we) marked[{row, col}] <= 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int a, input logic v, input logic we, input logic [5:0] r, input logic [5:0] c);
      req_valid[a] = v;
      req_we[a] = we;
      req_row[6*a +: 6] = r;
      req_col[6*a +: 6] = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic exp_rd [3];
      exp_rd = '{1'b0, 1'b1, 1'b1};
      // reset state
      repeat (2) step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_err", 32'(req_err), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_rdd", 32'(rd_data), 0);
      chk("rst_row", 32'(row), 0);
      chk("rst_col", 32'(col), 0);
      chk("rst_oe", 32'(maze_oe), 0);
      chk("rst_we", 32'(maze_we), 0);
      // start a read, then reset during WAIT_RD
      rst_n = 1'b1;
      drive(0, 1, 0, 6'd1, 6'd1);
      step();
      chk("pre_gnt", 32'(gnt), 1);
      chk("pre_oe", 32'(maze_oe), 1);
      chk("pre_addr", 32'({row, col}), 32'({6'd1, 6'd1}));
      drive(0, 0, 0, 6'd0, 6'd0);
      step();
      chk("pre_issue_done", 32'({gnt, maze_oe}), 0);
      rst_n = 1'b0;
      #1;
      chk("async_addr", 32'({row, col}), 0);
      chk("async_out", 32'({gnt, req_err, rd_valid, maze_oe, maze_we}), 0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("no_stale", 32'({gnt, rd_valid, maze_we, maze_oe}), 0);
      end
      // agents 0 and 1 read together; agent 0 first, then agent 1
      drive(0, 1, 0, 6'd5, 6'd7);
      drive(1, 1, 0, 6'd3, 6'd4);
      step();
      chk("r0_gnt", 32'(gnt), 32'b001);
      chk("r0_addr", 32'({row, col}), 32'({6'd5, 6'd7}));
      chk("r0_oe", 32'({maze_oe, maze_we}), 32'b10);
      drive(0, 0, 0, 6'd0, 6'd0);
      step();
      step();
      chk("r0_rdv", 32'(rd_valid), 32'b001);
      chk("r0_rdd", 32'(rd_data), 0);
      step();
      chk("r0_rdv_clr", 32'({rd_valid, gnt}), 0);
      step();
      chk("r1_gnt", 32'(gnt), 32'b010);
      chk("r1_addr", 32'({row, col}), 32'({6'd3, 6'd4}));
      chk("r1_oe", 32'(maze_oe), 1);
      drive(1, 0, 0, 6'd0, 6'd0);
      step();
      chk("r1_wait", 32'({gnt, maze_oe, rd_valid}), 0);
      step();
      chk("r1_rdv", 32'(rd_valid), 32'b010);
      chk("r1_rdd", 32'(rd_data), 1);
      step();
      chk("r1_rdv_clr", 32'(rd_valid), 0);
      chk("r1_rdd_hold", 32'(rd_data), 1);
      // write-mark by agent 0
      drive(0, 1, 1, 6'd0, 6'd10);
      step();
      chk("w_gnt", 32'(gnt), 32'b001);
      chk("w_strobe", 32'({maze_we, maze_oe}), 32'b10);
      chk("w_addr", 32'({row, col}), 32'({6'd0, 6'd10}));
      drive(0, 0, 0, 6'd0, 6'd0);
      step();
      chk("w_clr", 32'({gnt, maze_we, maze_oe}), 0);
      step();
      chk("w_no_rdv", 32'({rd_valid, maze_we}), 0);
      step();
      chk("w_no_rdv2", 32'(rd_valid), 0);
      // agent 2 reads back the marked cell
      drive(2, 1, 0, 6'd0, 6'd10);
      step();
      chk("rb_gnt", 32'(gnt), 32'b100);
      drive(2, 0, 0, 6'd0, 6'd0);
      step();
      step();
      chk("rb_rdv", 32'(rd_valid), 32'b100);
      chk("rb_rdd", 32'(rd_data), 1);
      step();
      // bounds: row 40 rejected
      drive(1, 1, 0, 6'd40, 6'd3);
      step();
      chk("oob_gnt", 32'(gnt), 32'b010);
      chk("oob_err", 32'(req_err), 32'b010);
      chk("oob_strobe", 32'({maze_oe, maze_we}), 0);
      chk("oob_row", 32'(row), 40);
      drive(1, 0, 0, 6'd0, 6'd0);
      step();
      chk("oob_clr", 32'({gnt, req_err, maze_oe, maze_we, rd_valid}), 0);
      // column exactly MAZE_DIM rejected, back in IDLE immediately
      drive(2, 1, 0, 6'd31, 6'd32);
      step();
      chk("edge_gnt", 32'(gnt), 32'b100);
      chk("edge_err", 32'(req_err), 32'b100);
      chk("edge_strobe", 32'({maze_oe, maze_we}), 0);
      drive(2, 0, 0, 6'd0, 6'd0);
      step();
      chk("edge_clr", 32'({req_err, rd_valid}), 0);
      // coordinates MAZE_DIM-1 are accepted
      drive(0, 1, 0, 6'd31, 6'd31);
      step();
      chk("max_gnt", 32'(gnt), 32'b001);
      chk("max_err", 32'(req_err), 0);
      chk("max_oe", 32'(maze_oe), 1);
      drive(0, 0, 0, 6'd0, 6'd0);
      step();
      step();
      chk("max_rdv", 32'(rd_valid), 32'b001);
      chk("max_rdd", 32'(rd_data), 0);
      step();
      // simultaneous write (agent 0) and read (agent 1) after reset
      do_reset();
      drive(0, 1, 1, 6'd4, 6'd4);
      drive(1, 1, 0, 6'd3, 6'd4);
      step();
      chk("sim_gnt0", 32'(gnt), 32'b001);
      chk("sim_we", 32'({maze_we, maze_oe}), 32'b10);
      drive(0, 0, 0, 6'd0, 6'd0);
      step();
      chk("sim_gap", 32'({gnt, maze_we}), 0);
      step();
      chk("sim_gnt1", 32'(gnt), 32'b010);
      chk("sim_oe", 32'({maze_oe, maze_we}), 32'b10);
      drive(1, 0, 0, 6'd0, 6'd0);
      step();
      step();
      chk("sim_rdv", 32'(rd_valid), 32'b010);
      chk("sim_rdd", 32'(rd_data), 1);
      step();
      // fairness with all agents reading continuously
      do_reset();
      drive(0, 1, 0, 6'd2, 6'd2);
      drive(1, 1, 0, 6'd3, 6'd4);
      drive(2, 1, 0, 6'd6, 6'd1);
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(1 << (i % 3)));
         step();
         step();
         chk($sformatf("rr_rdv%0d", i), 32'(rd_valid), 32'(1 << (i % 3)));
         chk($sformatf("rr_rdd%0d", i), 32'(rd_data), 32'(exp_rd[i % 3]));
         step();
      end
      req_valid = '0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maze_port_arbiter.md
Name: maze_port_arbiter

Overview:
- Shares the single synchronous maze memory port (row, col, maze_oe, maze_we, maze_in) between NUM_REQ solver agents.
- Each agent issues single read or write-mark requests. The arbiter picks one per transaction using round-robin, sequences the memory timing, and routes the read bit back to the winner.
- Sits between the solver instances and the maze memory model in the top level.
- Also bounds-checks coordinates so no agent can address outside the maze.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAZE_DIM, 64, valid coordinate range is 0..MAZE_DIM-1; must be at most 64.
- IDX_W, $clog2(NUM_REQ), width of the winner index (derived).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-agent request; held high until gnt is seen.
- req_we  in  NUM_REQ  1 = write-mark, 0 = read.
- req_row  in  6*NUM_REQ  packed row, agent i at [6i+5:6i].
- req_col  in  6*NUM_REQ  packed column, same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- req_err  out  NUM_REQ  one-hot pulse together with gnt when the request is rejected for out-of-range coordinates.
- rd_valid  out  NUM_REQ  one-hot, one-cycle pulse: rd_data is valid for that agent.
- rd_data  out  1  captured maze_in value (0 = corridor, 1 = wall).
- row, col  out  6 each  memory address, registered.
- maze_oe, maze_we  out  1 each  memory read and write enables, registered one-cycle pulses.
- maze_in  in  1  memory read data, valid in the cycle after the cycle in which maze_oe is high.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - All outputs 0: gnt, req_err, rd_valid, rd_data, row, col, maze_oe, maze_we.
  - Round-robin pointer last = NUM_REQ-1, so agent 0 wins first after reset.
- States: IDLE, ISSUE, WAIT_RD, CAPTURE (encodings defined in the package).
- IDLE:
  - If no req_valid is high, stay in IDLE.
  - Otherwise the winner w is the first agent with req_valid high, searching from last+1 and wrapping modulo NUM_REQ.
  - At the edge:
    - gnt[w] <= 1.
    - last <= w.
    - row/col <= the winner's coordinates.
  - If req_row[w] >= MAZE_DIM or req_col[w] >= MAZE_DIM:
    - req_err[w] <= 1.
    - maze_oe and maze_we stay 0.
    - Next state is ISSUE, and ISSUE then returns to IDLE.
  - Otherwise:
    - maze_we <= req_we[w].
    - maze_oe <= ~req_we[w].
    - Next state is ISSUE.
- ISSUE (gnt, and oe or we, are high for exactly this cycle):
  - At the edge, clear gnt, req_err, maze_oe, maze_we.
  - Next state: WAIT_RD if the request was a valid read, else IDLE.
  - req_valid is ignored in this state; the agent drops it at this edge.
- WAIT_RD:
  - maze_in is valid during this cycle.
  - At the edge: rd_data <= maze_in, rd_valid[w] <= 1, next state CAPTURE.
- CAPTURE:
  - rd_valid is high for this cycle.
  - At the edge: clear rd_valid, next state IDLE.
  - rd_data holds its value until the next capture.
- Latency:
  - Write: 2 cycles from IDLE acceptance back to IDLE, so one write every 2 cycles at most.
  - Read: rd_valid asserted 2 cycles after gnt; one read every 4 cycles at most.
- Fairness: the agent that was just served has the lowest priority on the next pick. With all NUM_REQ agents continuously requesting, grant order is 0,1,...,NUM_REQ-1,0.
- row and col hold the last issued address between transactions; they are not cleared.
- An agent that drops req_valid before it is granted is simply not picked; no error is raised.
- Asynchronous reset in any state returns to IDLE with all outputs zeroed. No stale rd_valid or maze_we may be emitted after reset is released.
- Only one transaction is in flight at a time; gnt, rd_valid and req_err are always at most one-hot.

Decomposition:
- Package maze_arb_pkg holds:
  - state encodings ST_IDLE/ST_ISSUE/ST_WAIT_RD/ST_CAPTURE;
  - COORD_W = 6;
  - the maze value constants CORRIDOR = 0 and WALL = 1.
- Sub-module rr_picker: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: winner index, any flag.
  - Parameterised by NUM_REQ.

Test Plan:
- Reset mid-read: assert rst_n low during WAIT_RD -> all outputs 0 immediately. After release, agent 0 requests (row 5, col 7) -> first gnt is agent 0, and no spurious rd_valid appears.
- Single read: agent 1 requests read (row 3, col 4); memory returns 1 -> gnt[1] in cycle T, maze_oe=1 with row=3/col=4 in T, rd_valid[1]=1 with rd_data=1 in T+2.
- Write: agent 0 requests write (row 0, col 10) -> maze_we pulses for exactly 1 cycle with row=0/col=10, maze_oe stays 0, and no rd_valid follows.
- Round-robin fairness: NUM_REQ=3, all agents request reads continuously for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2.
- Bounds check: MAZE_DIM=32, agent 1 requests read at row 40 -> gnt[1] and req_err[1] pulse together, maze_oe and maze_we never rise, and the FSM is back in IDLE 2 cycles later.
- Simultaneous events: agent 0 write and agent 1 read both asserted in the same cycle after reset -> agent 0 served first, agent 1 granted in the first IDLE cycle after the write, and agent 1's rd_valid is correct.
